seq_divider_2n_by_n: RTL and testbench
======================================

// Module: seq_divider_2n_by_n
// PURPOSE
// - Iterative restoring unsigned divider: 2N-bit dividend / N-bit divisor -> 2N-bit quotient, N-bit remainder.
// - Inverse companion to the combinational NxN tree multiplier in the arithmetic library.
// - Multi-cycle (one quotient bit per clock) with start/busy/valid handshake.
// - Feeds the multiplier/divider cross-check benches and the arithmetic datapath.
// PARAMETERS
// - N  default 4  divisor/remainder width; dividend and quotient are 2N bits
// PORTS
// - clk          in   1    single clock, rising edge
// - rst_n        in   1    asynchronous, active-low reset
// - start        in   1    request; operands sampled when start=1 and busy=0
// - dividend     in   2N   unsigned dividend
// - divisor      in   N    unsigned divisor
// - busy         out  1    iteration in progress
// - valid        out  1    results valid; held until next accepted start
// - quotient     out  2N   unsigned quotient
// - remainder    out  N    unsigned remainder, always < divisor when divisor!=0
// - div_by_zero  out  1    last accepted op had divisor==0; qualified by valid
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; busy=0, valid=0, quotient=0, remainder=0, div_by_zero=0.
// - Reset mid-operation aborts immediately; no partial result is ever flagged valid.
// - States:
//   - IDLE: start -> RUN.
//   - RUN: 2N iterations, then -> DONE.
//   - DONE: start -> RUN; otherwise hold.
// - Accept edge k (start=1, busy=0):
//   - Capture divisor; load quotient shift reg with dividend; clear partial remainder (N+1 bits).
//   - busy=1, valid=0.
// - Each RUN edge (one iteration):
//   - t = {r[N-1:0], q[2N-1]}, N+1 bits.
//   - If t >= d: r = t - d, shift 1 into q LSB; else r = t, shift 0.
// - Latency: iterations on edges k+1..k+2N. After edge k+2N: busy=0, valid=1, outputs final.
//   - N=4: busy high for 8 cycles.
// - start while busy=1 is ignored; in-flight operands are unaffected.
// - start on the cycle valid=1 is accepted: valid drops on that edge.
// - Divisor==0: accept edge goes straight to DONE; after edge k: valid=1, busy never asserts.
//   - quotient = all ones; remainder = dividend[N-1:0]; div_by_zero=1.
// - div_by_zero clears on next accepted start.
// - Outputs are registered; no combinational path from inputs to outputs.
// - Arithmetic is unsigned, no truncation: quotient holds the full 2N-bit result (max for divisor=1).
// CONFIGURATION
// - DIV_ZERO_DIVIDEND_FAST_EN:
//   - Defined: dividend==0 with divisor!=0 completes like the div-by-zero path.
//     - valid=1 after accept edge; quotient=0, remainder=0, div_by_zero=0, busy never asserts.
//   - Undefined: dividend==0 takes the full 2N-iteration path with identical final values.
// TESTING (N=4)
// - 200/13 -> after exactly 8 busy cycles: valid=1, quotient=15, remainder=5, div_by_zero=0.
// - 255/1 -> quotient=255, remainder=0.
// - 7/9 -> quotient=0, remainder=7.
// - 0x5A/0 -> valid=1 one edge after accept, busy=0 throughout; quotient=0xFF, remainder=0xA, div_by_zero=1.
// - Start 200/13, pulse start with 99/3 at iteration 3 -> ignored; result stays 15 r5.
//   - Then start 99/3 on the valid cycle -> 33 r0.
// - Start 200/13, drop rst_n at iteration 4 -> busy=valid=0 and outputs 0 immediately.
//   - After release, 100/7 -> 14 r2.
// - Exhaustive random vs golden model: quotient*divisor+remainder==dividend, remainder<divisor.
//   - Check under both macro settings; 0/5 takes 1 cycle with macro, 8 cycles without.

Source files
------------

// File: rtl/seq_divider_2n_by_n.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_DIVIDEND_FAST_EN: a zero dividend with a nonzero divisor finishes on the accept edge.
module seq_divider_2n_by_n #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           valid,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [2*N-1:0] q_reg;
  logic [N-1:0]   r_reg;
  logic [N-1:0]   d_reg;
  logic [CW-1:0]  iter_cnt;
  logic           dz_reg;

  logic           accept;
  logic           zero_div;
  logic           fast_zero;
  logic           last_iter;
  logic [N:0]     trial;
  logic           fits;
  logic [N-1:0]   trial_minus_d;

  // The partial remainder is always below the divisor, so the difference fits in N bits.
  always_comb begin
    accept        = start && (state != RUN);
    zero_div      = (divisor == '0);
`ifdef DIV_ZERO_DIVIDEND_FAST_EN
    fast_zero     = (dividend == '0) && !zero_div;
`else
    fast_zero     = 1'b0;
`endif
    last_iter     = (iter_cnt == CW'(2 * N - 1));
    trial         = {r_reg, q_reg[2*N-1]};
    fits          = (trial >= {1'b0, d_reg});
    trial_minus_d = trial[N-1:0] - d_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          next_state = (zero_div || fast_zero) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Short-circuit cases load their final result directly on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg    <= '0;
      r_reg    <= '0;
      d_reg    <= '0;
      iter_cnt <= '0;
      dz_reg   <= 1'b0;
    end else if (accept) begin
      d_reg    <= divisor;
      iter_cnt <= '0;
      if (zero_div) begin
        q_reg  <= '1;
        r_reg  <= dividend[N-1:0];
        dz_reg <= 1'b1;
      end else if (fast_zero) begin
        q_reg  <= '0;
        r_reg  <= '0;
        dz_reg <= 1'b0;
      end else begin
        q_reg  <= dividend;
        r_reg  <= '0;
        dz_reg <= 1'b0;
      end
    end else if (state == RUN) begin
      iter_cnt <= iter_cnt + CW'(1);
      if (fits) begin
        r_reg <= trial_minus_d;
        q_reg <= {q_reg[2*N-2:0], 1'b1};
      end else begin
        r_reg <= trial[N-1:0];
        q_reg <= {q_reg[2*N-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    busy        = (state == RUN);
    valid       = (state == DONE);
    quotient    = q_reg;
    remainder   = r_reg;
    div_by_zero = dz_reg;
  end

endmodule

// File: tb/tb_seq_divider_2n_by_n.sv
// Self-checking bench for seq_divider_2n_by_n (N=4): vector table, hand-written corner sequences and
// random operands, all results checked through an expected-result queue.
module tb_seq_divider_2n_by_n;

  localparam int N = 4;
`ifdef DIV_ZERO_DIVIDEND_FAST_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 2 * N;
`endif

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           valid;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;

  typedef struct {
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           dz;
    int             latency;
  } vec_t;

  typedef struct {
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           dz;
    int             latency;
    int             accept_cycle;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   failures  = 0;
  int   cycle_cnt = 0;

  seq_divider_2n_by_n #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .valid       (valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Golden model built on the language's own division operators.
  task automatic model(input logic [2*N-1:0] a, input logic [N-1:0] b,
                       output logic [2*N-1:0] q, output logic [N-1:0] r,
                       output logic dz, output int lat);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q   = '1;
      r   = a[N-1:0];
      dz  = 1'b1;
      lat = 0;
    end else begin
      q   = (2*N)'(ai / bi);
      r   = N'(ai % bi);
      dz  = 1'b0;
      lat = (ai == 0) ? ZERO_LAT : 2 * N;
    end
  endtask

  task automatic applyStimulus(input logic [2*N-1:0] a, input logic [N-1:0] b,
                               input logic [2*N-1:0] q, input logic [N-1:0] r,
                               input logic dz, input int lat);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start          = 1'b0;
    e.quotient     = q;
    e.remainder    = r;
    e.dz           = dz;
    e.latency      = lat;
    e.accept_cycle = cycle_cnt;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    int   waited;
    waited = 0;
    while (!valid && waited < 64) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!valid) begin
      tests_run++;
      failures++;
      $display("[TB] FAIL %s timeout: valid=0 after %0d cycles, expected 1", name, waited);
      if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    if (sb.size() == 0) begin
      tests_run++;
      failures++;
      $display("[TB] FAIL %s scoreboard: got valid with 0 queued results, expected 1", name);
      return;
    end
    e = sb.pop_front();
    check({name, " quotient"}, 32'(quotient), 32'(e.quotient));
    check({name, " remainder"}, 32'(remainder), 32'(e.remainder));
    check({name, " div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
    check({name, " busy_at_done"}, 32'(busy), 32'd0);
    check({name, " latency"}, 32'(cycle_cnt - e.accept_cycle), 32'(e.latency));
  endtask

  vec_t vecs[11];

  initial begin
    logic [2*N-1:0] ra;
    logic [N-1:0]   rb;
    logic [2*N-1:0] mq;
    logic [N-1:0]   mr;
    logic           mdz;
    int             mlat;
    exp_t           dropped;

    vecs[0]  = '{8'd200, 4'd13, 8'd15,  4'd5,  1'b0, 2 * N};
    vecs[1]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 2 * N};
    vecs[2]  = '{8'd7,   4'd9,  8'd0,   4'd7,  1'b0, 2 * N};
    vecs[3]  = '{8'h5A,  4'd0,  8'hFF,  4'hA,  1'b1, 0};
    vecs[4]  = '{8'd99,  4'd3,  8'd33,  4'd0,  1'b0, 2 * N};
    vecs[5]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, ZERO_LAT};
    vecs[6]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 2 * N};
    vecs[7]  = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 2 * N};
    vecs[8]  = '{8'hFF,  4'd0,  8'hFF,  4'hF,  1'b1, 0};
    vecs[9]  = '{8'd1,   4'd1,  8'd1,   4'd0,  1'b0, 2 * N};
    vecs[10] = '{8'd14,  4'd15, 8'd0,   4'd14, 1'b0, 2 * N};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].dividend, vecs[i].divisor, vecs[i].quotient,
                    vecs[i].remainder, vecs[i].dz, vecs[i].latency);
      if (vecs[i].divisor == '0) begin
        check($sformatf("vec%0d div0 busy_after_accept", i), 32'(busy), 32'd0);
      end
      checkOutput($sformatf("vec%0d", i));
    end

    // A start pulse mid-iteration must not disturb the running operands.
    applyStimulus(8'd200, 4'd13, 8'd15, 4'd5, 1'b0, 2 * N);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd99;
    divisor  = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ignored_start");
    applyStimulus(8'd99, 4'd3, 8'd33, 4'd0, 1'b0, 2 * N);
    check("restart valid_dropped", 32'(valid), 32'd0);
    check("restart busy", 32'(busy), 32'd1);
    checkOutput("restart_on_valid");

    // Asynchronous reset mid-operation clears everything without waiting for an edge.
    applyStimulus(8'd200, 4'd13, 8'd15, 4'd5, 1'b0, 2 * N);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(valid), 32'd0);
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    check("abort div_by_zero", 32'(div_by_zero), 32'd0);
    dropped = sb.pop_back();
    repeat (2) @(posedge clk);
    #1;
    check("abort held valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 2 * N);
    checkOutput("after_abort");

    for (int i = 0; i < 150; i++) begin
      ra = (2*N)'($urandom);
      rb = N'($urandom_range(0, 15));
      if ((i % 10) == 3) ra = '0;
      model(ra, rb, mq, mr, mdz, mlat);
      applyStimulus(ra, rb, mq, mr, mdz, mlat);
      checkOutput($sformatf("rand%0d %0d/%0d", i, ra, rb));
    end

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
